spi_reg_ctrl: RTL and testbench

- Sequences a SlaveSPI byte engine into a register-access protocol.
- Decodes the first byte of each CS frame as a command: read/write flag plus start address.
- Issues single-cycle register-file write/read strobes for the following bytes, with address auto-increment.
- Keeps the slave's DataToSend_i loaded with the next MISO byte.
- Sits between SlaveSPI (byte side) and a synchronous register file.

---
 rtl/spi_reg_ctrl.sv | 153 +++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_ctrl.sv
// Register-access sequencer between a SPI slave byte engine and a synchronous register file.
// Read data reaches ByteToSend_o 3 cycles after ByteDone_i; bytes arriving mid-fetch are dropped and flagged.
module spi_reg_ctrl #(
   parameter int         ADDR_WIDTH = 7,
   parameter logic [7:0] IDLE_BYTE  = 8'hA5,
   parameter bit         AUTO_INC   = 1'b1
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  CS_i,
   input  logic                  ByteDone_i,
   input  logic [7:0]            ByteReceived_i,
   output logic [7:0]            ByteToSend_o,
   output logic [ADDR_WIDTH-1:0] RegAddr_o,
   output logic [7:0]            RegWrData_o,
   output logic                  RegWrite_o,
   output logic                  RegRead_o,
   input  logic [7:0]            RegRdData_i,
   output logic                  FrameActive_o,
   output logic                  Overrun_o
);

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      WRITE,
      RD_REQ,
      RD_WAIT,
      READ
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic       cs_meta;
   logic       cs_s;
   logic [1:0] warm;
   logic       armed;
   logic       addr_load;
   logic       wr_take;
   logic       rd_capture;
   logic       overrun_set;

   // warm marks when cs_s holds a real sample rather than its reset value;
   // armed then requires a genuine CS-high before the first frame after reset.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         cs_meta <= 1'b1;
         cs_s    <= 1'b1;
         warm    <= 2'b00;
         armed   <= 1'b0;
      end else begin
         cs_meta <= CS_i;
         cs_s    <= cs_meta;
         warm    <= {warm[0], 1'b1};
         if (cs_s && warm[1]) begin
            armed <= 1'b1;
         end
      end
   end

   assign FrameActive_o = ~cs_s;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      addr_load   = 1'b0;
      wr_take     = 1'b0;
      rd_capture  = 1'b0;
      overrun_set = 1'b0;
      case (state)
         IDLE: begin
            if (armed && !cs_s) begin
               state_nxt = CMD;
            end
         end
         CMD: begin
            if (ByteDone_i) begin
               addr_load = 1'b1;
               state_nxt = ByteReceived_i[7] ? RD_REQ : WRITE;
            end
            if (cs_s) begin
               state_nxt = IDLE;
            end
         end
         WRITE: begin
            // A byte completing alongside CS release is still written.
            wr_take = ByteDone_i;
            if (cs_s) begin
               state_nxt = IDLE;
            end
         end
         RD_REQ: begin
            overrun_set = ByteDone_i;
            state_nxt   = cs_s ? IDLE : RD_WAIT;
         end
         RD_WAIT: begin
            overrun_set = ByteDone_i;
            rd_capture  = ~cs_s;
            state_nxt   = cs_s ? IDLE : READ;
         end
         READ: begin
            if (ByteDone_i) begin
               state_nxt = RD_REQ;
            end
            if (cs_s) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         ByteToSend_o <= IDLE_BYTE;
         RegAddr_o    <= '0;
         RegWrData_o  <= 8'h00;
         RegWrite_o   <= 1'b0;
         RegRead_o    <= 1'b0;
         Overrun_o    <= 1'b0;
      end else begin
         RegWrite_o <= wr_take;
         RegRead_o  <= (state_nxt == RD_REQ);
         if (wr_take) begin
            RegWrData_o <= ByteReceived_i;
         end
         // Increment follows the write strobe or the read-data capture cycle.
         if (addr_load) begin
            RegAddr_o <= ByteReceived_i[ADDR_WIDTH-1:0];
         end else if (AUTO_INC && (RegWrite_o || state == RD_WAIT)) begin
            RegAddr_o <= RegAddr_o + 1'b1;
         end
         if (state_nxt == IDLE) begin
            ByteToSend_o <= IDLE_BYTE;
         end else if (rd_capture) begin
            ByteToSend_o <= RegRdData_i;
         end
         if (overrun_set) begin
            Overrun_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: directed frame table, randomized frames against a transaction-level model,
// and hand-written abort / overrun / mid-frame reset sequences.
module tb_spi_reg_ctrl;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       CS_i = 1'b1;
   logic       ByteDone_i = 1'b0;
   logic [7:0] ByteReceived_i = 8'h00;
   logic [7:0] rd_data;

   logic [7:0] ByteToSend_o;
   logic [6:0] RegAddr_o;
   logic [7:0] RegWrData_o;
   logic       RegWrite_o;
   logic       RegRead_o;
   logic       FrameActive_o;
   logic       Overrun_o;

   logic [7:0] f_bts;
   logic [6:0] f_addr;
   logic [7:0] f_wd;
   logic       f_wr;
   logic       f_rd;
   logic       f_act;
   logic       f_ovr;

   always #5 Clock = ~Clock;

   spi_reg_ctrl dut (
      .Clock(Clock), .Reset(Reset), .CS_i(CS_i), .ByteDone_i(ByteDone_i),
      .ByteReceived_i(ByteReceived_i), .ByteToSend_o(ByteToSend_o), .RegAddr_o(RegAddr_o),
      .RegWrData_o(RegWrData_o), .RegWrite_o(RegWrite_o), .RegRead_o(RegRead_o),
      .RegRdData_i(rd_data), .FrameActive_o(FrameActive_o), .Overrun_o(Overrun_o)
   );

   spi_reg_ctrl #(.AUTO_INC(1'b0)) dut_fix (
      .Clock(Clock), .Reset(Reset), .CS_i(CS_i), .ByteDone_i(ByteDone_i),
      .ByteReceived_i(ByteReceived_i), .ByteToSend_o(f_bts), .RegAddr_o(f_addr),
      .RegWrData_o(f_wd), .RegWrite_o(f_wr), .RegRead_o(f_rd),
      .RegRdData_i(rd_data), .FrameActive_o(f_act), .Overrun_o(f_ovr)
   );

   // Register file attached to the main instance.
   logic [7:0] mem [128];
   always @(posedge Clock) begin
      if (RegWrite_o) mem[RegAddr_o] <= RegWrData_o;
      if (RegRead_o) rd_data <= mem[RegAddr_o];
   end

   // Access logs.
   logic [6:0] wa_q[$];
   logic [7:0] wd_q[$];
   logic [6:0] ra_q[$];
   logic [6:0] wf_q[$];
   logic [7:0] wfd_q[$];
   bit         both_hi = 1'b0;

   always @(negedge Clock) begin
      if (RegWrite_o) begin
         wa_q.push_back(RegAddr_o);
         wd_q.push_back(RegWrData_o);
      end
      if (RegRead_o) ra_q.push_back(RegAddr_o);
      if (f_wr) begin
         wf_q.push_back(f_addr);
         wfd_q.push_back(f_wd);
      end
      if ((RegWrite_o && RegRead_o) || (f_wr && f_rd)) both_hi = 1'b1;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge Clock);
   endtask

   task automatic cs_low();
      CS_i = 1'b0;
      cyc(4);
   endtask

   task automatic cs_high();
      cyc(6);
      CS_i = 1'b1;
      cyc(5);
   endtask

   task automatic pulse(input logic [7:0] b);
      ByteDone_i = 1'b1;
      ByteReceived_i = b;
      @(negedge Clock);
      ByteDone_i = 1'b0;
      ByteReceived_i = 8'h00;
   endtask

   // MISO is sampled when the slave would load its shift register.
   task automatic send_byte(input logic [7:0] b, output logic [7:0] miso);
      cyc(4);
      miso = ByteToSend_o;
      cyc(4);
      pulse(b);
   endtask

   task automatic clrq();
      wa_q.delete();
      wd_q.delete();
      ra_q.delete();
      wf_q.delete();
      wfd_q.delete();
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_bts"}, ByteToSend_o, 8'hA5);
      chk({tag, "_addr"}, RegAddr_o, 7'h00);
      chk({tag, "_wdat"}, RegWrData_o, 8'h00);
      chk({tag, "_wr"}, RegWrite_o, 1'b0);
      chk({tag, "_rd"}, RegRead_o, 1'b0);
      chk({tag, "_act"}, FrameActive_o, 1'b0);
      chk({tag, "_ovr"}, Overrun_o, 1'b0);
   endtask

   typedef struct packed {
      logic            rd;
      logic [2:0][7:0] b;
      logic [2:0][6:0] a;
      logic [1:0][7:0] w;
      logic [2:0][7:0] m;
      logic [6:0]      fa;
   } vec_t;

   function automatic vec_t mk(input logic rd, input logic [7:0] b0, b1, b2,
                               input logic [6:0] a0, a1, a2, input logic [7:0] w0, w1,
                               input logic [7:0] m0, m1, m2, input logic [6:0] fa);
      vec_t r;
      r.rd = rd;
      r.b[0] = b0; r.b[1] = b1; r.b[2] = b2;
      r.a[0] = a0; r.a[1] = a1; r.a[2] = a2;
      r.w[0] = w0; r.w[1] = w1;
      r.m[0] = m0; r.m[1] = m1; r.m[2] = m2;
      r.fa = fa;
      return r;
   endfunction

   vec_t       vecs[5];
   vec_t       v;
   logic [7:0] mb;
   logic [7:0] got[3];
   logic [7:0] ref_mem[128];
   logic [7:0] cmd;
   logic [7:0] dat;
   logic [6:0] start;
   logic [6:0] a;
   int         nd;
   logic [7:0] em[$];
   logic [6:0] ew_a[$];
   logic [7:0] ew_d[$];
   logic [6:0] er_a[$];

   initial begin
      // write frames list write addresses in a[0..1]; read frames list fetch addresses a[0..2]
      vecs[0] = mk(1'b0, 8'h05, 8'h11, 8'h22, 7'h05, 7'h06, 7'h00, 8'h11, 8'h22, 8'hA5, 8'hA5, 8'hA5, 7'h05);
      vecs[1] = mk(1'b0, 8'h03, 8'h33, 8'h55, 7'h03, 7'h04, 7'h00, 8'h33, 8'h55, 8'hA5, 8'hA5, 8'hA5, 7'h03);
      vecs[2] = mk(1'b1, 8'h83, 8'h00, 8'h00, 7'h03, 7'h04, 7'h05, 8'h00, 8'h00, 8'hA5, 8'h33, 8'h55, 7'h00);
      vecs[3] = mk(1'b0, 8'h7F, 8'hAA, 8'hBB, 7'h7F, 7'h00, 7'h00, 8'hAA, 8'hBB, 8'hA5, 8'hA5, 8'hA5, 7'h7F);
      vecs[4] = mk(1'b1, 8'hFF, 8'h12, 8'h34, 7'h7F, 7'h00, 7'h01, 8'h00, 8'h00, 8'hA5, 8'hAA, 8'hBB, 7'h00);
      for (int i = 0; i < 128; i++) ref_mem[i] = 8'h00;

      cyc(3);
      chk_reset("por");
      chk("por_fix_bts", f_bts, 8'hA5);
      chk("por_fix_act", f_act, 1'b0);
      chk("por_fix_ovr", f_ovr, 1'b0);
      Reset = 1'b0;
      cyc(4);

      // Clear the whole register file with one long write burst.
      clrq();
      cs_low();
      send_byte(8'h00, mb);
      for (int i = 0; i < 128; i++) send_byte(8'h00, mb);
      cs_high();
      chk("clear_count", wa_q.size(), 128);
      chk("clear_last_addr", wa_q[127], 7'h7F);

      for (int i = 0; i < 5; i++) begin
         v = vecs[i];
         clrq();
         cs_low();
         for (int k = 0; k < 3; k++) begin
            send_byte(v.b[k], mb);
            got[k] = mb;
         end
         cs_high();
         for (int k = 0; k < 3; k++) chk($sformatf("vec%0d_miso%0d", i, k), got[k], v.m[k]);
         if (v.rd) begin
            chk($sformatf("vec%0d_rd_count", i), ra_q.size(), 3);
            chk($sformatf("vec%0d_wr_count", i), wa_q.size(), 0);
            for (int k = 0; k < 3; k++)
               if (ra_q.size() > k) chk($sformatf("vec%0d_rd_addr%0d", i, k), ra_q[k], v.a[k]);
         end else begin
            chk($sformatf("vec%0d_wr_count", i), wa_q.size(), 2);
            chk($sformatf("vec%0d_fix_count", i), wf_q.size(), 2);
            for (int k = 0; k < 2; k++) begin
               ref_mem[v.a[k]] = v.w[k];
               if (wa_q.size() > k) begin
                  chk($sformatf("vec%0d_wr_addr%0d", i, k), wa_q[k], v.a[k]);
                  chk($sformatf("vec%0d_wr_data%0d", i, k), wd_q[k], v.w[k]);
               end
               if (wf_q.size() > k) begin
                  chk($sformatf("vec%0d_fix_addr%0d", i, k), wf_q[k], v.fa);
                  chk($sformatf("vec%0d_fix_data%0d", i, k), wfd_q[k], v.w[k]);
               end
            end
         end
      end

      // Randomized frames against a transaction-level model.
      for (int f = 0; f < 25; f++) begin
         cmd = 8'($urandom);
         nd = $urandom_range(0, 4);
         start = cmd[6:0];
         clrq();
         em.delete(); ew_a.delete(); ew_d.delete(); er_a.delete();
         cs_low();
         send_byte(cmd, mb);
         chk($sformatf("rnd%0d_miso0", f), mb, 8'hA5);
         if (cmd[7]) er_a.push_back(start);
         for (int k = 1; k <= nd; k++) begin
            dat = 8'($urandom);
            a = start + 7'(k) - 7'd1;
            if (cmd[7]) begin
               em.push_back(ref_mem[a]);
               er_a.push_back(start + 7'(k));
            end else begin
               em.push_back(8'hA5);
               ew_a.push_back(a);
               ew_d.push_back(dat);
               ref_mem[a] = dat;
            end
            send_byte(dat, mb);
            chk($sformatf("rnd%0d_miso%0d", f, k), mb, em[k-1]);
         end
         cs_high();
         chk($sformatf("rnd%0d_wr_count", f), wa_q.size(), ew_a.size());
         chk($sformatf("rnd%0d_rd_count", f), ra_q.size(), er_a.size());
         for (int k = 0; k < ew_a.size(); k++)
            if (wa_q.size() > k) begin
               chk($sformatf("rnd%0d_wr_addr%0d", f, k), wa_q[k], ew_a[k]);
               chk($sformatf("rnd%0d_wr_data%0d", f, k), wd_q[k], ew_d[k]);
            end
         for (int k = 0; k < er_a.size(); k++)
            if (ra_q.size() > k) chk($sformatf("rnd%0d_rd_addr%0d", f, k), ra_q[k], er_a[k]);
      end

      // Abort: CS released mid data byte, then a complete frame.
      clrq();
      cs_low();
      send_byte(8'h10, mb);
      cyc(4);
      CS_i = 1'b1;
      cyc(5);
      chk("abort_no_write", wa_q.size(), 0);
      chk("abort_bts", ByteToSend_o, 8'hA5);
      chk("abort_inactive", FrameActive_o, 1'b0);
      cs_low();
      send_byte(8'h10, mb);
      send_byte(8'h99, mb);
      cs_high();
      chk("abort_next_count", wa_q.size(), 1);
      if (wa_q.size() > 0) begin
         chk("abort_next_addr", wa_q[0], 7'h10);
         chk("abort_next_data", wd_q[0], 8'h99);
      end

      // Overrun: second byte lands while the fetch is still pending.
      clrq();
      chk("ovr_pre", Overrun_o, 1'b0);
      cs_low();
      send_byte(8'h85, mb);
      cyc(4);
      pulse(8'h00);
      cyc(1);
      pulse(8'h00);
      cyc(6);
      chk("ovr_set", Overrun_o, 1'b1);
      chk("ovr_rd_count", ra_q.size(), 2);
      if (ra_q.size() > 1) chk("ovr_rd_addr1", ra_q[1], 7'h06);
      cs_high();
      cyc(10);
      chk("ovr_sticky", Overrun_o, 1'b1);

      // Reset during a write frame with CS held low.
      clrq();
      cs_low();
      send_byte(8'h20, mb);
      send_byte(8'h44, mb);
      cyc(3);
      Reset = 1'b1;
      #1;
      chk_reset("mid");
      cyc(2);
      Reset = 1'b0;
      cyc(4);
      send_byte(8'h30, mb);
      send_byte(8'h77, mb);
      cyc(6);
      chk("mid_hold_wr_count", wa_q.size(), 1);
      chk("mid_hold_rd_count", ra_q.size(), 0);
      if (wa_q.size() > 0) chk("mid_pre_addr", wa_q[0], 7'h20);
      CS_i = 1'b1;
      cyc(5);
      cs_low();
      send_byte(8'h30, mb);
      send_byte(8'h77, mb);
      cs_high();
      chk("mid_after_count", wa_q.size(), 2);
      if (wa_q.size() > 1) begin
         chk("mid_after_addr", wa_q[1], 7'h30);
         chk("mid_after_data", wd_q[1], 8'h77);
      end

      chk("strobe_exclusive", both_hi, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
